if_id_ex_front: RTL and testbench
=================================

Name: if_id_ex_front

Overview:
- Pipeline front end that consumes the load-use stall controls (pc_write, ifid_write, haz_mux_con) from the hazard unit.
- Holds the PC register, the IF/ID pipeline register and the ID/EX control/register-address latch.
- Applies stalls by freezing PC and IF/ID, and inserts bubbles by zeroing ID/EX control.
- Feeds ex_rt and ex_mem_read back to the hazard unit, which closes the detection loop.

Parameters:
- AW, 16, PC / instruction-address width.
- IW, 16, instruction width.
- CW, 8, decoded control-bundle width.
- MEMREAD_BIT, 3, index of the MemRead bit inside the control bundle.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- pc_write  in  1  1 = PC may update; 0 = hold PC.
- ifid_write  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- haz_mux_con  in  1  1 = pass decoded control into ID/EX; 0 = insert bubble (all-zero control).
- branch_taken  in  1  redirect fetch; flush younger stages.
- branch_target  in  AW  redirect address.
- imem_rdata  in  IW  instruction at imem_addr (combinational memory).
- id_ctrl  in  CW  decoded control for the instruction in IF/ID.
- id_rs  in  4  rs field of the instruction in IF/ID.
- id_rt  in  4  rt field of the instruction in IF/ID.
- imem_addr  out  AW  current PC.
- ifid_instr  out  IW  IF/ID instruction.
- ifid_pc1  out  AW  IF/ID PC+1.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ex_ctrl  out  CW  ID/EX control bundle.
- ex_rs  out  4  ID/EX rs.
- ex_rt  out  4  ID/EX rt (to hazard unit EXRegRt).
- ex_mem_read  out  1  ex_ctrl[MEMREAD_BIT] (to hazard unit EXMemRead).
- ex_valid  out  1  ID/EX holds a real (non-bubble) instruction.

Behaviour:
- Reset: rst_n sampled low at a rising edge loads:
  - pc = RESET_PC.
  - ifid_instr = 0, ifid_pc1 = 0, ifid_valid = 0.
  - ex_ctrl = 0, ex_rs = 0, ex_rt = 0, ex_valid = 0.
  - Reset dominates all other inputs and may occur mid-stall or mid-branch.
- imem_addr = pc, combinational. ex_mem_read = ex_ctrl[MEMREAD_BIT], combinational.
- Priority each edge: reset > branch_taken > stall/normal.
- branch_taken = 1:
  - pc <= branch_target. This ignores pc_write.
  - IF/ID flushes: instr = 0, pc1 = 0, valid = 0. This ignores ifid_write.
  - ID/EX takes a bubble: ctrl = 0, rs = 0, rt = 0, valid = 0.
- Normal operation, branch_taken = 0:
  - PC: if pc_write, pc <= pc + 1, truncated to AW bits; 0xFFFF wraps to 0x0000. Otherwise pc holds.
  - IF/ID: if ifid_write, instr <= imem_rdata, pc1 <= pc + 1 (same wrap), valid <= 1. Otherwise all IF/ID fields hold.
  - ID/EX: if haz_mux_con && ifid_valid, then ctrl <= id_ctrl, rs <= id_rs, rt <= id_rt, valid <= 1.
  - ID/EX otherwise: ctrl <= 0, rs <= 0, rt <= 0, valid <= 0. ID/EX always loads; it never holds.
- Latency: an instruction fetched at edge N is in IF/ID after N and in ID/EX after N+1, absent stalls.
- Load-use stall (pc_write = 0, ifid_write = 0, haz_mux_con = 0 for one cycle):
  - PC and IF/ID freeze.
  - Exactly one bubble enters ID/EX.
  - The next cycle re-presents the same IF/ID instruction.
- pc_write and ifid_write are independent. Any combination is legal and is applied literally.
- ID/EX loads a bubble whenever ifid_valid = 0, regardless of haz_mux_con.

Optional Feature:
- Macro STALL_CNT_EN.
- When defined:
  - Adds output stall_count, 16 bits.
  - Reset to 0.
  - Increments on each edge where rst_n = 1, branch_taken = 0 and pc_write = 0.
  - Saturates at 0xFFFF; no wrap.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset then release, imem_rdata = 0x1234, all writes 1:
  - After edge 1: imem_addr = 1, ifid_instr = 0x1234, ifid_pc1 = 1, ifid_valid = 1.
  - After edge 2: ex_valid = 1.
- Free run for 4 edges with id_ctrl = 0x08, id_rt = 5:
  - PC steps 0→1→2→3→4.
  - ex_ctrl = 0x08, ex_mem_read = 1, ex_rt = 5 from edge 2 onward.
- One-cycle stall (pc_write = 0, ifid_write = 0, haz_mux_con = 0) at pc = 3:
  - pc stays 3 and ifid_instr is unchanged.
  - ex_ctrl = 0, ex_valid = 0 for one cycle.
  - On the next edge the same instruction enters ID/EX.
- Simultaneous branch and stall (branch_taken = 1, branch_target = 0x0040, pc_write = 0):
  - pc = 0x0040, ifid_valid = 0, ex_valid = 0.
- pc = 0xFFFF with pc_write = 1: next pc = 0x0000 and ifid_pc1 = 0x0000.
- rst_n low during a stall: all outputs return to reset values after one edge.
  - With STALL_CNT_EN: 3 stalled edges give stall_count = 3, and reset returns it to 0.

Source files
------------

// File: rtl/if_id_ex_front_if.sv
// if_id_ex_front_if
//   Bundles the stall controls from the hazard unit, the branch redirect, the
//   instruction-memory port, the decoded ID fields and the ID/EX outputs of
//   the pipeline front end.
//   master : hazard unit / decoder / memory side (drives the controls).
//   slave  : if_id_ex_front (drives PC, IF/ID and ID/EX state).
//   Optional macro STALL_CNT_EN adds the 16-bit stall_count signal.
interface if_id_ex_front_if #(
   parameter int AW = 16,
   parameter int IW = 16,
   parameter int CW = 8
);
   logic          pc_write;
   logic          ifid_write;
   logic          haz_mux_con;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic [IW-1:0] imem_rdata;
   logic [CW-1:0] id_ctrl;
   logic [3:0]    id_rs;
   logic [3:0]    id_rt;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] ifid_instr;
   logic [AW-1:0] ifid_pc1;
   logic          ifid_valid;
   logic [CW-1:0] ex_ctrl;
   logic [3:0]    ex_rs;
   logic [3:0]    ex_rt;
   logic          ex_mem_read;
   logic          ex_valid;
`ifdef STALL_CNT_EN
   logic [15:0]   stall_count;
`endif

   modport master (
      output pc_write, ifid_write, haz_mux_con, branch_taken, branch_target,
             imem_rdata, id_ctrl, id_rs, id_rt,
`ifdef STALL_CNT_EN
      input  stall_count,
`endif
      input  imem_addr, ifid_instr, ifid_pc1, ifid_valid, ex_ctrl, ex_rs,
             ex_rt, ex_mem_read, ex_valid
   );

   modport slave (
      input  pc_write, ifid_write, haz_mux_con, branch_taken, branch_target,
             imem_rdata, id_ctrl, id_rs, id_rt,
`ifdef STALL_CNT_EN
      output stall_count,
`endif
      output imem_addr, ifid_instr, ifid_pc1, ifid_valid, ex_ctrl, ex_rs,
             ex_rt, ex_mem_read, ex_valid
   );
endinterface

// File: rtl/if_id_ex_front.sv
// if_id_ex_front
//   Pipeline front end: PC register, IF/ID register and ID/EX control /
//   register-address latch. Applies load-use stalls from the hazard unit by
//   freezing PC and IF/ID, and inserts bubbles by zeroing ID/EX control.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : if_id_ex_front_if.slave (controls in, PC / IF/ID / ID/EX out)
//   Priority each edge: reset > branch_taken > stall/normal.
//   Optional macro STALL_CNT_EN: saturating 16-bit count of edges where the
//   PC was held by the hazard unit (bus.stall_count).
module if_id_ex_front #(
   parameter int            AW          = 16,
   parameter int            IW          = 16,
   parameter int            CW          = 8,
   parameter int            MEMREAD_BIT = 3,
   parameter logic [AW-1:0] RESET_PC    = '0
) (
   input logic             clk,
   input logic             rst_n,
   if_id_ex_front_if.slave bus
);
   logic [AW-1:0] pc;
   logic [AW-1:0] pcPlus1;
   logic [IW-1:0] ifidInstr;
   logic [AW-1:0] ifidPc1;
   logic          ifidValid;
   logic [CW-1:0] exCtrl;
   logic [3:0]    exRs;
   logic [3:0]    exRt;
   logic          exValid;

   assign pcPlus1 = pc + {{(AW-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         ifidInstr <= '0;
         ifidPc1   <= '0;
         ifidValid <= 1'b0;
         exCtrl    <= '0;
         exRs      <= '0;
         exRt      <= '0;
         exValid   <= 1'b0;
      end else if (bus.branch_taken) begin
         pc        <= bus.branch_target;
         ifidInstr <= '0;
         ifidPc1   <= '0;
         ifidValid <= 1'b0;
         exCtrl    <= '0;
         exRs      <= '0;
         exRt      <= '0;
         exValid   <= 1'b0;
      end else begin
         if (bus.pc_write) pc <= pcPlus1;
         if (bus.ifid_write) begin
            ifidInstr <= bus.imem_rdata;
            ifidPc1   <= pcPlus1;
            ifidValid <= 1'b1;
         end
         // ID/EX never holds: it takes the decoded bundle or a bubble.
         if (bus.haz_mux_con && ifidValid) begin
            exCtrl  <= bus.id_ctrl;
            exRs    <= bus.id_rs;
            exRt    <= bus.id_rt;
            exValid <= 1'b1;
         end else begin
            exCtrl  <= '0;
            exRs    <= '0;
            exRt    <= '0;
            exValid <= 1'b0;
         end
      end
   end

`ifdef STALL_CNT_EN
   logic [15:0] stallCount;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCount <= '0;
      end else if (!bus.branch_taken && !bus.pc_write && (stallCount != '1)) begin
         stallCount <= stallCount + 16'd1;
      end
   end

   assign bus.stall_count = stallCount;
`endif

   assign bus.imem_addr   = pc;
   assign bus.ifid_instr  = ifidInstr;
   assign bus.ifid_pc1    = ifidPc1;
   assign bus.ifid_valid  = ifidValid;
   assign bus.ex_ctrl     = exCtrl;
   assign bus.ex_rs       = exRs;
   assign bus.ex_rt       = exRt;
   assign bus.ex_mem_read = exCtrl[MEMREAD_BIT];
   assign bus.ex_valid    = exValid;
endmodule

// File: tb/tb_if_id_ex_front.sv
// tb_if_id_ex_front
//   Randomized scoreboard bench for if_id_ex_front. The driver applies one
//   set of inputs per cycle, advances a reference model of the front end and
//   queues the expected post-edge outputs; the monitor pops and compares
//   #1 after each rising edge. Build with +define+STALL_CNT_EN to also check
//   the stall counter.
module tb_if_id_ex_front;
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] pc1;
      logic        ivalid;
      logic [7:0]  ctrl;
      logic [3:0]  rs;
      logic [3:0]  rt;
      logic        evalid;
      logic [15:0] scnt;
   } state_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   bit   done;
   state_t model;
   state_t expQ[$];

   if_id_ex_front_if #(.AW(16), .IW(16), .CW(8)) bus ();

   if_id_ex_front #(
      .AW(16), .IW(16), .CW(8), .MEMREAD_BIT(3), .RESET_PC(16'h0000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Combinational instruction memory: a fixed pseudo-random image with the
   // word at address 0 pinned to 0x1234.
   function automatic logic [15:0] memFn(input logic [15:0] a);
      logic [15:0] h;
      h = a * 16'h9E37;
      return (a == 16'h0000) ? 16'h1234 : (h ^ 16'h5A5A);
   endfunction

   assign bus.imem_rdata = memFn(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Apply inputs away from the edge, then at the edge advance the model.
   task automatic step(input logic rn, input logic br, input logic [15:0] tgt,
                       input logic pw, input logic iw, input logic hm,
                       input logic [7:0] ctrl, input logic [3:0] rs,
                       input logic [3:0] rt);
      state_t o;
      state_t n;
      @(negedge clk);
      rst_n             = rn;
      bus.branch_taken  = br;
      bus.branch_target = tgt;
      bus.pc_write      = pw;
      bus.ifid_write    = iw;
      bus.haz_mux_con   = hm;
      bus.id_ctrl       = ctrl;
      bus.id_rs         = rs;
      bus.id_rt         = rt;
      @(posedge clk);
      o = model;
      n = o;
      if (!rn) begin
         n = '0;
      end else if (br) begin
         n        = '0;
         n.pc     = tgt;
         n.scnt   = o.scnt;
      end else begin
         if (hm && o.ivalid) begin
            n.ctrl = ctrl; n.rs = rs; n.rt = rt; n.evalid = 1'b1;
         end else begin
            n.ctrl = '0; n.rs = '0; n.rt = '0; n.evalid = 1'b0;
         end
         if (iw) begin
            n.instr  = memFn(o.pc);
            n.pc1    = 16'(o.pc + 16'd1);
            n.ivalid = 1'b1;
         end
         if (pw) n.pc = 16'(o.pc + 16'd1);
         else if (o.scnt != 16'hFFFF) n.scnt = o.scnt + 16'd1;
      end
      model = n;
      expQ.push_back(n);
   endtask

   // Monitor: compares every queued expectation one step after its edge.
   initial begin
      state_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("imem_addr",   32'(bus.imem_addr),   32'(e.pc));
            chk("ifid_instr",  32'(bus.ifid_instr),  32'(e.instr));
            chk("ifid_pc1",    32'(bus.ifid_pc1),    32'(e.pc1));
            chk("ifid_valid",  32'(bus.ifid_valid),  32'(e.ivalid));
            chk("ex_ctrl",     32'(bus.ex_ctrl),     32'(e.ctrl));
            chk("ex_rs",       32'(bus.ex_rs),       32'(e.rs));
            chk("ex_rt",       32'(bus.ex_rt),       32'(e.rt));
            chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.ctrl[3]));
            chk("ex_valid",    32'(bus.ex_valid),    32'(e.evalid));
`ifdef STALL_CNT_EN
            chk("stall_count", 32'(bus.stall_count), 32'(e.scnt));
`endif
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      done   = 1'b0;
      model  = '0;
      rst_n  = 1'b0;
      bus.branch_taken = 1'b0; bus.branch_target = '0;
      bus.pc_write = 1'b1; bus.ifid_write = 1'b1; bus.haz_mux_con = 1'b1;
      bus.id_ctrl = '0; bus.id_rs = '0; bus.id_rt = '0;

      // Reset, then free run with a MemRead bundle.
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h00, 4'd0, 4'd0);
      for (int unsigned i = 0; i < 3; i++)
         step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h08, 4'd2, 4'd5);
      // One-cycle load-use stall at pc = 3, then resume.
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h08, 4'd2, 4'd5);
      step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h08, 4'd2, 4'd5);
      step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h08, 4'd2, 4'd5);
      // Branch together with a stall.
      step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd7, 4'd9);
      step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h0C, 4'd1, 4'd3);
      // PC wrap at 0xFFFF.
      step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 8'h00, 4'd0, 4'd0);
      step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h01, 4'd4, 4'd6);
      step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h02, 4'd4, 4'd6);
      // Reset clears the counter, three stalled edges, then reset mid-stall.
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h00, 4'd0, 4'd0);
      step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h08, 4'd3, 4'd8);
      for (int unsigned i = 0; i < 3; i++)
         step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h08, 4'd3, 4'd8);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h08, 4'd3, 4'd8);

      // Randomized traffic: independent writes plus grouped load-use stalls.
      for (int unsigned i = 0; i < 400; i++) begin
         logic rn, br, pw, iw, hm;
         logic [15:0] tgt;
         rn  = ($urandom_range(0, 99) >= 3);
         br  = ($urandom_range(0, 99) < 10);
         tgt = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            pw = 1'b0; iw = 1'b0; hm = 1'b0;
         end else begin
            pw = ($urandom_range(0, 99) < 80);
            iw = ($urandom_range(0, 99) < 80);
            hm = ($urandom_range(0, 99) < 80);
         end
         step(rn, br, tgt, pw, iw, hm, 8'($urandom), 4'($urandom), 4'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", expQ.size());
      end
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL timeout actual=running required=finished");
         $fatal(1);
      end
   end
endmodule
